// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared types and widths for the AD1 converter scheduler.
// Holds the FSM state encoding and the converter result width.
package adc_sched_pkg;

  localparam int unsigned ADC_W = 12;

  // Scheduler FSM state encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    START   = 3'd2,
    CONVERT = 3'd3,
    RESPOND = 3'd4
  } state_t;

endpackage

// File: rtl/adc_scheduler_if.sv
// adc_scheduler_if: requester and converter signals of the AD1 scheduler.
//   req/chan_sel        requester level request and channel select
//   grant               one-hot plate-drive grant
//   rsp_valid/data/err  one-hot response strobe, result, timeout flag
//   busy                scheduler not idle
//   adc_start/done      converter start pulse and done pulse
//   adc_data1/2         converter channel results
// master: the scheduler. slave: requesters plus converter front end.
interface adc_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  import adc_sched_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  chan_sel;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  rsp_valid;
  logic [ADC_W-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data1;
  logic [ADC_W-1:0] adc_data2;

  modport master (
    input  req, chan_sel, adc_done, adc_data1, adc_data2,
    output grant, rsp_valid, rsp_data, rsp_err, busy, adc_start
  );

  modport slave (
    output req, chan_sel, adc_done, adc_data1, adc_data2,
    input  grant, rsp_valid, rsp_data, rsp_err, busy, adc_start
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req  request vector
//   ptr  index searched first; search wraps modulo NREQ
//   idx  first set request at or after ptr (0 when none)
//   any  at least one request set
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Walk from ptr upwards; the first hit wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = IDX_W'((32'(ptr) + i) % NREQ);
      if (!any && req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scheduler.sv
// adc_scheduler: shares the AD1 converter among NREQ requesters.
// Per transaction: grant, settle, start pulse, wait for done (bounded by
// a timeout), then strobe the selected channel result back.
//   clock  sole clock
//   reset  asynchronous, active-high
//   bus    adc_scheduler_if.master (requester and converter signals)
module adc_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned SETTLE_CYCLES  = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             reset,
  adc_scheduler_if.master  bus
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SLOAD  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned TLOAD  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             chan_q, chan_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ADC_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .idx (arb_idx),
    .any (arb_any)
  );

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      chan_q      <= 1'b0;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      chan_q      <= chan_d;
      scnt_q      <= scnt_d;
      tcnt_q      <= tcnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; outputs are computed for the next state so they register
  // in step with it
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    chan_d      = chan_q;
    scnt_d      = scnt_q;
    tcnt_d      = tcnt_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_idx_d = arb_idx;
          chan_d    = bus.chan_sel[arb_idx];
          if (SETTLE_CYCLES == 0) begin
            state_d = START;
          end else begin
            state_d = SETTLE;
            scnt_d  = SCNT_W'(SLOAD);
          end
        end
      end
      SETTLE: begin
        if (scnt_q == '0) state_d = START;
        else              scnt_d  = scnt_q - SCNT_W'(1);
      end
      START: begin
        tcnt_d  = TCNT_W'(TLOAD);
        state_d = CONVERT;
      end
      CONVERT: begin
        // done takes priority over the last timeout cycle
        if (bus.adc_done) begin
          state_d     = RESPOND;
          rsp_valid_d = NREQ'(1) << gnt_idx_q;
          rsp_data_d  = chan_q ? bus.adc_data2 : bus.adc_data1;
          rsp_err_d   = 1'b0;
        end else if (tcnt_q == '0) begin
          state_d     = RESPOND;
          rsp_valid_d = NREQ'(1) << gnt_idx_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q - TCNT_W'(1);
        end
      end
      RESPOND: begin
        rr_ptr_d = IDX_W'((32'(gnt_idx_q) + 32'd1) % NREQ);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    grant_d = (state_d != IDLE) ? (NREQ'(1) << gnt_idx_d) : '0;
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.adc_start = start_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// tb_adc_scheduler: directed bench for adc_scheduler (NREQ=4, settle 3,
// timeout 8). Inputs change on the falling edge, outputs sampled there too.
module tb_adc_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  adc_scheduler_if #(.NREQ(4)) bus ();

  adc_scheduler #(
    .NREQ           (4),
    .SETTLE_CYCLES  (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Steps until adc_start is seen; n counts steps taken
  task automatic wait_start(output int n);
    n = 0;
    while (bus.adc_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("start_seen", 32'(bus.adc_start), 32'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid === 4'b0000 && n < 64) begin
      step();
      n++;
    end
    check("rsp_seen", 32'(|bus.rsp_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int strobes;
    logic [3:0] seen;
    logic [3:0] exp_g;

    bus.req       = '0;
    bus.chan_sel  = '0;
    bus.adc_done  = 1'b0;
    bus.adc_data1 = '0;
    bus.adc_data2 = '0;

    // Reset values
    step();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.adc_start), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_data", 32'(bus.rsp_data), 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    step();
    reset = 1'b0;

    // Basic transaction: settle 3, done 5 cycles after start
    bus.req = 4'b0001;
    step();
    check("t1_grant_settle", 32'(bus.grant), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_start(n);
    check("t1_start_lat", 32'(n + 1), 32'd4);
    check("t1_grant_start", 32'(bus.grant), 32'h1);
    repeat (4) begin
      step();
      check("t1_start_pulse", 32'(bus.adc_start), 32'd0);
    end
    step();
    bus.adc_done  = 1'b1;
    bus.adc_data1 = 12'hABC;
    bus.adc_data2 = 12'h123;
    step();
    bus.adc_done = 1'b0;
    bus.req      = 4'b0000;
    check("t1_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1_data", 32'(bus.rsp_data), 32'hABC);
    check("t1_err", 32'(bus.rsp_err), 32'd0);
    check("t1_grant_rsp", 32'(bus.grant), 32'h1);
    step();
    check("t1_idle_grant", 32'(bus.grant), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    check("t1_valid_once", 32'(bus.rsp_valid), 32'd0);
    check("t1_data_hold", 32'(bus.rsp_data), 32'hABC);

    // Channel select: requester 2 reads data2
    bus.chan_sel  = 4'b0100;
    bus.req       = 4'b0100;
    bus.adc_data1 = 12'h111;
    bus.adc_data2 = 12'h222;
    wait_start(n);
    check("t3_grant", 32'(bus.grant), 32'h4);
    step();
    bus.adc_done = 1'b1;
    step();
    bus.adc_done = 1'b0;
    bus.req      = 4'b0000;
    bus.chan_sel = 4'b0000;
    check("t3_valid", 32'(bus.rsp_valid), 32'h4);
    check("t3_data", 32'(bus.rsp_data), 32'h222);

    // Round robin with all requests held, from rr_ptr = 0
    do_reset();
    bus.req = 4'b1111;
    seen    = '0;
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      wait_start(n);
      check("rr_grant", 32'(bus.grant), 32'(exp_g));
      step();
      bus.adc_done  = 1'b1;
      bus.adc_data1 = 12'(32'h100 + 32'(k));
      step();
      bus.adc_done = 1'b0;
      check("rr_valid", 32'(bus.rsp_valid), 32'(exp_g));
      check("rr_data", 32'(bus.rsp_data), 32'h100 + 32'(k));
      if (k < 4) begin
        seen    = seen | bus.rsp_valid;
        strobes = strobes + $countones(bus.rsp_valid);
      end
    end
    bus.req = 4'b0000;
    check("rr_round_cover", 32'(seen), 32'hF);
    check("rr_round_count", 32'(strobes), 32'd4);

    // Timeout: done never arrives, then the next request is served
    step();
    bus.req = 4'b0010;
    wait_start(n);
    wait_rsp(n);
    check("to_convert_len", 32'(n - 1), 32'd8);
    check("to_valid", 32'(bus.rsp_valid), 32'h2);
    check("to_err", 32'(bus.rsp_err), 32'd1);
    check("to_data", 32'(bus.rsp_data), 32'd0);
    bus.req = 4'b1000;
    wait_start(n);
    check("to_next_grant", 32'(bus.grant), 32'h8);
    step();
    bus.adc_done  = 1'b1;
    bus.adc_data1 = 12'h3C5;
    step();
    bus.adc_done = 1'b0;
    bus.req      = 4'b0000;
    check("to_next_valid", 32'(bus.rsp_valid), 32'h8);
    check("to_next_err", 32'(bus.rsp_err), 32'd0);
    check("to_next_data", 32'(bus.rsp_data), 32'h3C5);

    // Reset in CONVERT aborts without a response; later done ignored
    step();
    bus.req = 4'b0001;
    wait_start(n);
    step();
    reset   = 1'b1;
    bus.req = 4'b0000;
    #1;
    check("rc_grant", 32'(bus.grant), 32'd0);
    check("rc_busy", 32'(bus.busy), 32'd0);
    check("rc_start", 32'(bus.adc_start), 32'd0);
    step();
    step();
    reset = 1'b0;
    bus.adc_done = 1'b1;
    step();
    bus.adc_done = 1'b0;
    seen = '0;
    exp_g = '0;
    repeat (12) begin
      step();
      seen  = seen | bus.rsp_valid;
      exp_g = exp_g | {3'b000, bus.busy};
    end
    check("rc_no_valid", 32'(seen), 32'd0);
    check("rc_no_busy", 32'(exp_g), 32'd0);

    // done during START is ignored -> timeout
    bus.req = 4'b0001;
    wait_start(n);
    bus.adc_done  = 1'b1;
    bus.adc_data1 = 12'h555;
    step();
    bus.adc_done = 1'b0;
    wait_rsp(n);
    check("ds_len", 32'(n + 1), 32'd9);
    check("ds_err", 32'(bus.rsp_err), 32'd1);
    check("ds_data", 32'(bus.rsp_data), 32'd0);

    // done in the final timeout cycle wins
    wait_start(n);
    repeat (8) step();
    bus.adc_done  = 1'b1;
    bus.adc_data1 = 12'h7E1;
    step();
    bus.adc_done = 1'b0;
    bus.req      = 4'b0000;
    check("dl_valid", 32'(bus.rsp_valid), 32'h1);
    check("dl_err", 32'(bus.rsp_err), 32'd0);
    check("dl_data", 32'(bus.rsp_data), 32'h7E1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
